// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the requesters (loader, fetch, data), the unified RAM
// and the arbiter. The arbiter connects through the slave modport.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              ld_req;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_done;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_done;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [1:0]        owner;
  logic              busy;
  logic              cpu_stall;

  modport slave (
    input  ld_req, ld_we, ld_addr, ld_wdata,
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output ld_done, if_done, dm_done, rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output owner, busy, cpu_stall
  );

  modport master (
    output ld_req, ld_we, ld_addr, ld_wdata,
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  ld_done, if_done, dm_done, rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  owner, busy, cpu_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port unified RAM among loader (LD), instruction
// fetch (IF) and data access (DM). One access at a time through
// IDLE -> ISSUE -> WAIT -> RESP, with an anti-starvation boost for IF.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                RST,
  mem_port_arbiter_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_IF   = 2'b01;
  localparam logic [1:0] OWN_DM   = 2'b10;
  localparam logic [1:0] OWN_LD   = 2'b11;

  localparam int unsigned LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [1:0]        state_q,     state_d;
  logic [LAT_W-1:0]  lat_cnt_q,   lat_cnt_d;
  logic [STV_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [1:0]        owner_q,     owner_d;
  logic              busy_q,      busy_d;
  logic              mem_en_q,    mem_en_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic              ld_done_q,   ld_done_d;
  logic              if_done_q,   if_done_d;
  logic              dm_done_q,   dm_done_d;

  logic              if_boost;

  // Next-state, arbitration and starvation bookkeeping.
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    owner_d      = owner_q;
    busy_d       = busy_q;
    mem_en_d     = 1'b0;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rdata_d      = rdata_q;
    ld_done_d    = 1'b0;
    if_done_d    = 1'b0;
    dm_done_d    = 1'b0;
    if_boost     = bus.if_req && (starve_cnt_q == STV_W'(STARVE_MAX));

    case (state_q)
      S_IDLE: begin
        if (!bus.if_req) starve_cnt_d = '0;
        if (bus.ld_req || bus.if_req || bus.dm_req) begin
          state_d  = S_ISSUE;
          mem_en_d = 1'b1;
          busy_d   = 1'b1;
          if (bus.ld_req) begin
            owner_d     = OWN_LD;
            mem_we_d    = bus.ld_we;
            mem_addr_d  = bus.ld_addr;
            mem_wdata_d = bus.ld_wdata;
          end else if (bus.if_req && (if_boost || !bus.dm_req)) begin
            owner_d      = OWN_IF;
            mem_we_d     = 1'b0;
            mem_addr_d   = bus.if_addr;
            mem_wdata_d  = '0;
            starve_cnt_d = '0;
          end else begin
            owner_d     = OWN_DM;
            mem_we_d    = bus.dm_we;
            mem_addr_d  = bus.dm_addr;
            mem_wdata_d = bus.dm_wdata;
            if (bus.if_req && (starve_cnt_q != STV_W'(STARVE_MAX)))
              starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        lat_cnt_d = LAT_W'(MEM_LAT - 1);
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (lat_cnt_q == '0) begin
          if (!mem_we_q) rdata_d = bus.mem_rdata;
          state_d   = S_RESP;
          ld_done_d = (owner_q == OWN_LD);
          if_done_d = (owner_q == OWN_IF);
          dm_done_d = (owner_q == OWN_DM);
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: begin
        owner_d = OWN_NONE;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      owner_q      <= OWN_NONE;
      busy_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rdata_q      <= '0;
      ld_done_q    <= 1'b0;
      if_done_q    <= 1'b0;
      dm_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      owner_q      <= owner_d;
      busy_q       <= busy_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      rdata_q      <= rdata_d;
      ld_done_q    <= ld_done_d;
      if_done_q    <= if_done_d;
      dm_done_q    <= dm_done_d;
    end
  end

  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.ld_done   = ld_done_q;
  assign bus.if_done   = if_done_q;
  assign bus.dm_done   = dm_done_q;
  assign bus.cpu_stall = (bus.if_req & ~if_done_q) | (bus.dm_req & ~dm_done_q);

endmodule
